// File: rtl/npc_pkg.sv
// Shared NPC definitions: access-size encodings, LSU FSM states, reset PC.
package npc_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane helper: store mask/lane replication, load extraction/extension and alignment check.
module npc_lsu_align
    import npc_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes of the SRAM word.
    always_comb begin
        byte_s = 8'h00;
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Size decode; the illegal size 2'b11 yields all-zero outputs and is flagged by the caller.
    always_comb begin
        wmask      = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        misalign   = 1'b0;
        case (size)
            SZ_B: begin
                wmask      = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{~is_unsigned & byte_s[7]}}, byte_s};
            end
            SZ_H: begin
                wmask      = 4'b0011 << {addr[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{~is_unsigned & half_s[15]}}, half_s};
                misalign   = addr[0];
            end
            SZ_W: begin
                wmask      = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
                misalign   = (addr != 2'b00);
            end
            default: begin
                wmask      = 4'b0000;
                wdata_lane = 32'h0000_0000;
                rdata_ext  = 32'h0000_0000;
                misalign   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// Load/store unit between the EXU memory port and the data SRAM: one request in flight,
// one-cycle SRAM request pulse, bounded wait for the response, registered response.
module npc_lsu
    import npc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lat_wen_r;
    logic [1:0]       lat_addr_r;
    logic [1:0]       lat_size_r;
    logic             lat_uns_r;

    logic [1:0]  al_addr_s;
    logic [1:0]  al_size_s;
    logic        al_uns_s;
    logic [3:0]  wmask_s;
    logic [31:0] wdata_lane_s;
    logic [31:0] rdata_ext_s;
    logic        misalign_s;
    logic        bad_req_s;

    // The aligner sees the live request while idle and the latched request afterwards.
    always_comb begin
        if (state_r == IDLE) begin
            al_addr_s = req_addr[1:0];
            al_size_s = req_size;
            al_uns_s  = req_unsigned;
        end else begin
            al_addr_s = lat_addr_r;
            al_size_s = lat_size_r;
            al_uns_s  = lat_uns_r;
        end
    end

    npc_lsu_align u_align (
        .addr        (al_addr_s),
        .size        (al_size_s),
        .is_unsigned (al_uns_s),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .wmask       (wmask_s),
        .wdata_lane  (wdata_lane_s),
        .rdata_ext   (rdata_ext_s),
        .misalign    (misalign_s)
    );

    assign bad_req_s = misalign_s | (req_size == 2'b11);
    assign req_ready = (state_r == IDLE);

    // Request FSM with all memory-side and response-side outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            lat_wen_r  <= 1'b0;
            lat_addr_r <= 2'b00;
            lat_size_r <= 2'b00;
            lat_uns_r  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= {DATA_W{1'b0}};
            rsp_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            mem_wmask  <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        lat_wen_r  <= req_wen;
                        lat_addr_r <= req_addr[1:0];
                        lat_size_r <= req_size;
                        lat_uns_r  <= req_unsigned;
                        if (bad_req_s) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {DATA_W{1'b0}};
                            state_r   <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_wen   <= req_wen;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= req_wen ? wdata_lane_s : {DATA_W{1'b0}};
                            mem_wmask <= req_wen ? wmask_s : 4'b0000;
                            state_r   <= REQ;
                        end
                    end
                end
                REQ: begin
                    mem_req   <= 1'b0;
                    mem_wen   <= 1'b0;
                    mem_addr  <= {ADDR_W{1'b0}};
                    mem_wdata <= {DATA_W{1'b0}};
                    mem_wmask <= 4'b0000;
                    cnt_r     <= {CNT_W{1'b0}};
                    state_r   <= WAIT;
                end
                WAIT: begin
                    // A response arriving in the final wait cycle still beats the timeout.
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= lat_wen_r ? {DATA_W{1'b0}} : rdata_ext_s;
                        state_r   <= RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= {DATA_W{1'b0}};
                        state_r   <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= {DATA_W{1'b0}};
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_lsu.sv
// Directed scoreboard bench for npc_lsu (TIMEOUT shortened to 8).
module tb_npc_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    npc_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_req      (mem_req),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
        chk({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_wen"},   {31'd0, mem_wen}, 32'd0);
        chk({tag, "_mem_addr"},  mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
    endtask

    // One complete transaction: drive, track mem side, compare the scoreboarded response.
    task automatic do_req(
        input string       tag,
        input logic        wen,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic        uns,
        input int          delay,
        input logic [31:0] rd,
        input int          rdy_delay,
        input logic [31:0] exp_rd,
        input logic        exp_err,
        input int          exp_lat,
        input logic        exp_mem,
        input logic [3:0]  exp_mask,
        input logic [31:0] exp_wd
    );
        int   lat;
        int   extra;
        exp_t e;
        chk({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        sb.push_back('{exp_rd, exp_err, exp_lat});
        tick();
        lat       = 1;
        req_valid = 1'b0;
        chk({tag, "_mem_req_t1"}, {31'd0, mem_req}, {31'd0, exp_mem});
        if (exp_mem) begin
            chk({tag, "_mem_addr"},  mem_addr, {addr[31:2], 2'b00});
            chk({tag, "_mem_wen"},   {31'd0, mem_wen}, {31'd0, wen});
            chk({tag, "_mem_wmask"}, {28'd0, mem_wmask}, {28'd0, exp_mask});
            chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
        end
        extra = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (lat >= 2 && mem_req === 1'b1) extra++;
            if (delay >= 0 && lat == delay + 2) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            tick();
            lat++;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
        chk({tag, "_mem_req_once"}, extra, 32'd0);
        chk({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
        e = sb.pop_front();
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        // Stray illegal-size requests while the response is pending must be ignored.
        for (int i = 0; i < rdy_delay; i++) begin
            req_valid = 1'b1;
            req_size  = 2'b11;
            tick();
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, e.err});
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, "_after_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_after_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        chk({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_idle_mem_req"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'hDEAD_BEEF;
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle_outputs("post_reset");

        //      tag     wen   addr           wdata          sz     uns   dly rd            rdy exp_rd         err  lat mem   mask     wd
        do_req("lb",   1'b0, 32'h8000_0003, 32'h0,         2'b00, 1'b0, 0, 32'h80FF_7F01, 0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, 4'b0000, 32'h0);
        do_req("lbu",  1'b0, 32'h8000_0003, 32'h0,         2'b00, 1'b1, 0, 32'h80FF_7F01, 0, 32'h0000_0080, 1'b0, 3, 1'b1, 4'b0000, 32'h0);
        do_req("sh",   1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'b01, 1'b0, 3, 32'h5A5A_5A5A, 0, 32'h0,         1'b0, 6, 1'b1, 4'b1100, 32'hABCD_ABCD);
        do_req("lw_mis", 1'b0, 32'h8000_0002, 32'h0,       2'b10, 1'b0, -1, 32'h0,        0, 32'h0,         1'b1, 1, 1'b0, 4'b0000, 32'h0);
        do_req("sz11", 1'b0, 32'h8000_0000, 32'h0,         2'b11, 1'b0, -1, 32'h0,        0, 32'h0,         1'b1, 1, 1'b0, 4'b0000, 32'h0);
        do_req("sh_mis", 1'b1, 32'h8000_0001, 32'hFFFF,    2'b01, 1'b0, -1, 32'h0,        0, 32'h0,         1'b1, 1, 1'b0, 4'b0000, 32'h0);
        do_req("tmo",  1'b0, 32'h8000_0000, 32'h0,         2'b10, 1'b0, -1, 32'h0,        0, 32'h0,         1'b1, 10, 1'b1, 4'b0000, 32'h0);
        do_req("tmo_last", 1'b0, 32'h8000_0002, 32'h0,     2'b01, 1'b0, 7, 32'h8001_1234, 0, 32'hFFFF_8001, 1'b0, 10, 1'b1, 4'b0000, 32'h0);
        do_req("lhu_hold", 1'b0, 32'h8000_0000, 32'h0,     2'b01, 1'b1, 2, 32'h5555_F00D, 3, 32'h0000_F00D, 1'b0, 5, 1'b1, 4'b0000, 32'h0);
        do_req("sb",   1'b1, 32'h8000_0001, 32'h0000_00A5, 2'b00, 1'b0, 1, 32'h1111_1111, 0, 32'h0,         1'b0, 4, 1'b1, 4'b0010, 32'hA5A5_A5A5);
        do_req("sw",   1'b1, 32'h8000_0004, 32'hCAFE_F00D, 2'b10, 1'b0, 0, 32'h2222_2222, 1, 32'h0,         1'b0, 3, 1'b1, 4'b1111, 32'hCAFE_F00D);

        // Reset while waiting on the SRAM, then a stray response that must be ignored.
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0008;
        req_size  = 2'b10;
        tick();
        req_valid = 1'b0;
        chk("rstw_mem_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("rstw_in_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rstw_async");
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk_idle_outputs("rstw_stray");
        tick();
        chk("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_req("lw_after", 1'b0, 32'h8000_0004, 32'h0, 2'b10, 1'b0, 1, 32'h1357_9BDF, 0, 32'h1357_9BDF, 1'b0, 4, 1'b1, 4'b0000, 32'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
Load/store unit sitting directly downstream of the EXU memory port, between EXU and the DPI-C data SRAM.
- Accepts one memory request at a time from EXU over a valid/ready handshake.
- Builds the word-aligned SRAM access with byte mask and shifted write data.
- Waits a variable number of cycles for the SRAM response, with a timeout.
- Returns load data, sign- or zero-extended, or a write ack, with an error flag.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; fixed at 32, no other value supported
TIMEOUT, 255, max WAIT cycles before error; counter width is clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  zero-extend load (lbu/lhu)
rsp_valid  out  1  response valid
rsp_ready  in  1  EXU accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size or timeout
mem_req  out  1  one-cycle SRAM request pulse
mem_wen  out  1  SRAM write enable
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte enables
mem_rvalid  in  1  SRAM response/ack; latency is at least 1 cycle
mem_rdata  in  32  SRAM read word

Behaviour:
- Reset: state IDLE. req_ready=1 (combinational from IDLE). All other outputs 0. Latched request and timeout counter cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wen/addr/wdata/size/unsigned.
  - If size==11, or half with addr[0]!=0, or word with addr[1:0]!=0: go to RESP with err=1; no mem_req is ever issued.
  - Otherwise go to REQ.
- REQ: mem_req=1 for exactly one cycle. mem_wen/mem_addr/mem_wdata/mem_wmask are valid in this cycle. Clear counter, go to WAIT.
- WAIT:
  - mem_rvalid=1: capture rdata (load) or 0 (store), err=0, go to RESP.
  - Else counter++. When counter==TIMEOUT-1 with no rvalid: err=1, rdata=0, go to RESP.
  - rvalid in the timeout cycle wins (no error).
- RESP:
  - rsp_valid=1, with rdata/err registered and held stable until rsp_ready.
  - On rsp_ready, go to IDLE. No new request is accepted in the same cycle; req_ready=0 outside IDLE.
- mem_rvalid is ignored in IDLE, REQ and RESP.
- Store mask:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Loads: mem_wmask=0 and mem_wdata=0.
- Load extract:
  - byte: lane addr[1:0] of mem_rdata.
  - half: lane addr[1].
  - Sign-extend unless req_unsigned; word is passed through.
- Latency: aligned access accepted at cycle T gives mem_req at T+1. With rvalid at T+2, rsp_valid is at T+3. A misaligned access gives rsp_valid at T+1.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared. A late mem_rvalid after reset is ignored, because the FSM is in IDLE.

Decomposition:
Shared package npc_pkg holds:
- localparams SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
- lsu_state_t enum {IDLE,REQ,WAIT,RESP}
- RESET_PC 32'h8000_0000

Sub-module npc_lsu_align is purely combinational. It takes addr[1:0], size, unsigned, wdata and rdata, and produces wmask, wdata_lane, rdata_ext and misalign. It is reused by the future cached LSU.

Test Plan:
- lb addr 0x80000003, mem_rdata 0x80FF7F01 after 1 cycle -> mem_addr 0x80000000, mem_wmask 0, rsp_rdata 0xFFFFFF80, err 0, rsp_valid at T+3; same access with lbu -> 0x00000080.
- sh addr 0x80000002, wdata 0x1234ABCD -> mem_wen 1, mem_wmask 4'b1100, mem_wdata 0xABCDABCD; ack after 4 cycles -> rsp_rdata 0, err 0.
- lw addr 0x80000002, and a req_size=11 access -> mem_req never asserted, rsp_valid at T+1 with err 1.
- TIMEOUT=8, load with mem_rvalid never asserted -> rsp_err 1 after 8 WAIT cycles; repeat with rvalid in the last WAIT cycle -> err 0 with data.
- rsp_ready held low 3 cycles -> rsp_valid/rdata/err stable, req_ready 0, extra req_valid not accepted; accepted only after return to IDLE.
- rst pulse in WAIT, then stray mem_rvalid -> all outputs 0, req_ready 1, no rsp_valid; next lw 0x80000004 completes normally.
